pe_array_ctrl: RTL and testbench

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/pe_array_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: job sequencer for a PE array.
// A job loads a mode into the PEs, broadcasts num_filt_pkts filter packets,
// then runs num_rounds convolution rounds and pulses done.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, mode_cfg,     job start and configuration, sampled only in IDLE
//   num_filt_pkts,
//   num_rounds
//   filt_src_valid/ready filter broadcast handshake
//   ifmap_src_valid/ready ifmap broadcast handshake (ready gated by pe_full)
//   pe_full, pe_conv_done, pe_error  per-PE status
//   op_stage, mode_out, change_mode, conv_continue  PE broadcast controls
//   busy, done, err      job status
module pe_array_ctrl #(
  parameter int unsigned NUM_PE = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode_cfg,
  input  logic [CNT_W-1:0]  num_filt_pkts,
  input  logic [CNT_W-1:0]  num_rounds,
  input  logic              filt_src_valid,
  output logic              filt_src_ready,
  input  logic              ifmap_src_valid,
  output logic              ifmap_src_ready,
  input  logic [NUM_PE-1:0] pe_full,
  input  logic [NUM_PE-1:0] pe_conv_done,
  input  logic [NUM_PE-1:0] pe_error,
  output logic [1:0]        op_stage,
  output logic [1:0]        mode_out,
  output logic              change_mode,
  output logic              conv_continue,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned SETTLE_CYC = 2;
  localparam logic [1:0]  STG_IDLE   = 2'd0;
  localparam logic [1:0]  STG_LOAD   = 2'd1;
  localparam logic [1:0]  STG_CONV   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_LOAD_F, S_CONV, S_FIN, S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] num_pkts;
  logic [CNT_W-1:0] rounds_m1;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] round_cnt;
  logic [1:0]       settle;

  // Ready must not depend on valid, so the ifmap valid is not needed here.
  logic ifmap_valid_unused;
  assign ifmap_valid_unused = ifmap_src_valid;

  // Any full scratch pad stalls the ifmap broadcast in the same cycle.
  assign ifmap_src_ready = (state == S_CONV) && !(|pe_full);

  // Sequencer: outputs are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      num_pkts       <= '0;
      rounds_m1      <= '0;
      pkt_cnt        <= '0;
      round_cnt      <= '0;
      settle         <= '0;
      filt_src_ready <= 1'b0;
      op_stage       <= STG_IDLE;
      mode_out       <= 2'd0;
      change_mode    <= 1'b0;
      conv_continue  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      change_mode   <= 1'b0;
      conv_continue <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_out    <= mode_cfg;
            num_pkts    <= num_filt_pkts;
            // Zero rounds runs a single round.
            rounds_m1   <= (num_rounds == '0) ? '0 : num_rounds - CNT_W'(1);
            pkt_cnt     <= '0;
            round_cnt   <= '0;
            change_mode <= 1'b1;
            busy        <= 1'b1;
            state       <= S_CFG;
          end
        end
        S_CFG: begin
          if (num_pkts != '0) begin
            filt_src_ready <= 1'b1;
            op_stage       <= STG_LOAD;
            state          <= S_LOAD_F;
          end else begin
            conv_continue <= 1'b1;
            settle        <= 2'(SETTLE_CYC);
            op_stage      <= STG_CONV;
            state         <= S_CONV;
          end
        end
        S_LOAD_F: begin
          if (|pe_error) begin
            filt_src_ready <= 1'b0;
            op_stage       <= STG_IDLE;
            err            <= 1'b1;
            state          <= S_ERR;
          end else if (filt_src_valid) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (pkt_cnt + CNT_W'(1) == num_pkts) begin
              filt_src_ready <= 1'b0;
              conv_continue  <= 1'b1;
              settle         <= 2'(SETTLE_CYC);
              op_stage       <= STG_CONV;
              state          <= S_CONV;
            end
          end
        end
        S_CONV: begin
          // pe_conv_done is stale for the first cycles after a (re)start.
          if (settle != 2'd0) settle <= settle - 2'd1;
          if (|pe_error) begin
            op_stage <= STG_IDLE;
            err      <= 1'b1;
            state    <= S_ERR;
          end else if (settle == 2'd0 && &pe_conv_done) begin
            if (round_cnt == rounds_m1) begin
              op_stage <= STG_IDLE;
              done     <= 1'b1;
              state    <= S_FIN;
            end else begin
              round_cnt     <= round_cnt + CNT_W'(1);
              conv_continue <= 1'b1;
              settle        <= 2'(SETTLE_CYC);
            end
          end
        end
        S_FIN: begin
          pkt_cnt   <= '0;
          round_cnt <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized bench for pe_array_ctrl. Each job's stimulus is generated up
// front; a model predicts the phase of every cycle from event times
// (packet accepts, round completions, first error) and the outputs follow.
module tb_pe_array_ctrl;

  localparam int unsigned NUM_PE = 24;
  localparam int unsigned CNT_W  = 8;
  localparam int          MAXL   = 160;
  localparam int          LIM    = MAXL - 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        mode_cfg;
  logic [CNT_W-1:0]  num_filt_pkts;
  logic [CNT_W-1:0]  num_rounds;
  logic              filt_src_valid;
  logic              filt_src_ready;
  logic              ifmap_src_valid;
  logic              ifmap_src_ready;
  logic [NUM_PE-1:0] pe_full;
  logic [NUM_PE-1:0] pe_conv_done;
  logic [NUM_PE-1:0] pe_error;
  logic [1:0]        op_stage;
  logic [1:0]        mode_out;
  logic              change_mode;
  logic              conv_continue;
  logic              busy;
  logic              done;
  logic              err;

  pe_array_ctrl #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_cfg(mode_cfg),
    .num_filt_pkts(num_filt_pkts), .num_rounds(num_rounds),
    .filt_src_valid(filt_src_valid), .filt_src_ready(filt_src_ready),
    .ifmap_src_valid(ifmap_src_valid), .ifmap_src_ready(ifmap_src_ready),
    .pe_full(pe_full), .pe_conv_done(pe_conv_done), .pe_error(pe_error),
    .op_stage(op_stage), .mode_out(mode_out), .change_mode(change_mode),
    .conv_continue(conv_continue), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_CFG, P_LOAD, P_CONV, P_FIN, P_ERR} phase_t;

  // Per-cycle stimulus of the current job (cycle 0 carries start).
  logic              s_start [MAXL];
  logic              s_valid [MAXL];
  logic              s_ivalid[MAXL];
  logic [NUM_PE-1:0] s_full  [MAXL];
  logic [NUM_PE-1:0] s_cdone [MAXL];
  logic [NUM_PE-1:0] s_perr  [MAXL];
  logic [1:0]        j_mode;
  logic [CNT_W-1:0]  j_n;
  logic [CNT_W-1:0]  j_r;

  phase_t ph[MAXL];
  logic   cc[MAXL];
  int     last_mode;
  int     n_pass;
  int     n_checks;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [10:0] obs_vec();
    return {op_stage, mode_out, change_mode, conv_continue, busy, done, err,
            filt_src_ready, ifmap_src_ready};
  endfunction

  function automatic logic [10:0] exp_vec(input int c);
    logic [1:0] op;
    logic [1:0] md;
    op = (ph[c] == P_LOAD) ? 2'd1 : (ph[c] == P_CONV) ? 2'd2 : 2'd0;
    md = (c == 0) ? 2'(last_mode) : j_mode;
    return {op, md, ph[c] == P_CFG, cc[c], ph[c] != P_IDLE, ph[c] == P_FIN,
            ph[c] == P_ERR, ph[c] == P_LOAD, (ph[c] == P_CONV) && (s_full[c] == '0)};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXL; i++) begin
      s_start[i] = 1'b0; s_valid[i] = 1'b0; s_ivalid[i] = 1'b0;
      s_full[i]  = '0;   s_cdone[i] = '1;   s_perr[i]   = '0;
    end
    s_start[0] = 1'b1;
  endtask

  // Phase timeline from the job's event times.
  task automatic predict(output int endc, output int fate, output int got, output int ec);
    int c;
    int entry;
    int rdone;
    int rounds;
    for (int i = 0; i < MAXL; i++) begin ph[i] = P_IDLE; cc[i] = 1'b0; end
    ph[1] = P_CFG;
    c = 2; got = 0; fate = 0; ec = 0; rdone = 0;
    rounds = (j_r == '0) ? 1 : int'(j_r);
    while (int'(j_n) != got && fate == 0 && c < LIM) begin
      ph[c] = P_LOAD;
      if (s_valid[c]) got++;
      if (|s_perr[c]) fate = 2;
      c++;
    end
    entry = c;
    while (fate == 0 && c < LIM) begin
      ph[c] = P_CONV;
      cc[c] = (c == entry);
      if (|s_perr[c]) fate = 2;
      else if (c >= entry + 2 && &s_cdone[c]) begin
        rdone++;
        if (rdone == rounds) fate = 1;
        else entry = c + 1;
      end
      c++;
    end
    if (fate == 1) begin
      ph[c] = P_FIN;
      endc = c + 4;
    end else if (fate == 2) begin
      ec = c;
      for (int i = c; i < MAXL; i++) ph[i] = P_ERR;
      endc = c + 6;
    end else begin
      endc = LIM;
    end
  endtask

  task automatic drive(input int c);
    start           = s_start[c];
    mode_cfg        = (c == 0) ? j_mode : 2'($urandom);
    num_filt_pkts   = (c == 0) ? j_n : CNT_W'($urandom);
    num_rounds      = (c == 0) ? j_r : CNT_W'($urandom);
    filt_src_valid  = s_valid[c];
    ifmap_src_valid = s_ivalid[c];
    pe_full         = s_full[c];
    pe_conv_done    = s_cdone[c];
    pe_error        = s_perr[c];
  endtask

  task automatic quiet_inputs();
    start = 1'b0; mode_cfg = '0; num_filt_pkts = '0; num_rounds = '0;
    filt_src_valid = 1'b0; ifmap_src_valid = 1'b0;
    pe_full = '0; pe_conv_done = '1; pe_error = '0;
  endtask

  // Entered and left at posedge+1.
  task automatic reset_dut(input string tag);
    quiet_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    check(tag, 32'(obs_vec()), 32'd0);
    rst = 1'b0;
    last_mode = 0;
  endtask

  task automatic run_job(input int jid);
    int endc;
    int fate;
    int got;
    int ec;
    int acc;
    predict(endc, fate, got, ec);
    // A start while in ERR must be ignored.
    if (fate == 2) s_start[ec + 2] = 1'b1;
    acc = 0;
    for (int c = 0; c < endc; c++) begin
      drive(c);
      @(negedge clk);
      if (filt_src_valid && filt_src_ready) acc++;
      check($sformatf("job%0d_cyc%0d_outs", jid, c), 32'(obs_vec()), 32'(exp_vec(c)));
      @(posedge clk); #1;
    end
    check($sformatf("job%0d_accepts", jid), 32'(acc), 32'(got));
    last_mode = int'(j_mode);
    if (fate == 2) reset_dut($sformatf("job%0d_err_rst", jid));
  endtask

  task automatic random_job();
    clear_stim();
    j_mode = 2'($urandom);
    j_n    = CNT_W'($urandom_range(0, 6));
    j_r    = CNT_W'($urandom_range(0, 4));
    for (int i = 1; i <= 4; i++) s_start[i] = ($urandom_range(0, 3) == 0);
    for (int i = 1; i < MAXL; i++) begin
      s_valid[i]  = 1'($urandom_range(0, 1));
      s_ivalid[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) s_full[i][$urandom_range(0, NUM_PE - 1)] = 1'b1;
      if ($urandom_range(0, 1) == 0) s_cdone[i] = NUM_PE'($urandom);
    end
    if ($urandom_range(0, 3) == 0) s_perr[$urandom_range(1, 30)][$urandom_range(0, NUM_PE - 1)] = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_checks = 0; last_mode = 0;
    quiet_inputs();
    start = 1'b1;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(obs_vec()), 32'd0);
    rst = 1'b0;

    // Nominal job: mode 2, 3 packets, 2 rounds, everything ready.
    clear_stim();
    j_mode = 2'd2; j_n = 8'd3; j_r = 8'd2;
    for (int i = 1; i < MAXL; i++) s_valid[i] = 1'b1;
    run_job(0);

    // Filter bubbles 1,0,1,0,1.
    clear_stim();
    j_mode = 2'd1; j_n = 8'd3; j_r = 8'd1;
    s_valid[2] = 1'b1; s_valid[4] = 1'b1; s_valid[6] = 1'b1;
    run_job(1);

    // Backpressure from pe_full[5] for 4 cycles in CONV.
    clear_stim();
    j_mode = 2'd3; j_n = 8'd0; j_r = 8'd1;
    for (int i = 1; i < MAXL; i++) begin
      s_ivalid[i] = 1'b1;
      s_cdone[i]  = (i >= 12) ? '1 : '0;
    end
    for (int i = 5; i <= 8; i++) s_full[i][5] = 1'b1;
    run_job(2);

    // Error coincident with the first possible round completion.
    clear_stim();
    j_mode = 2'd0; j_n = 8'd0; j_r = 8'd1;
    s_perr[4][0] = 1'b1;
    run_job(3);

    // Zero packets and zero rounds: one round.
    clear_stim();
    j_mode = 2'd2; j_n = 8'd0; j_r = 8'd0;
    run_job(4);

    // Reset in the middle of a filter load.
    clear_stim();
    j_mode = 2'd3; j_n = 8'd5; j_r = 8'd1;
    for (int c = 0; c < 4; c++) begin
      drive(c);
      @(posedge clk); #1;
    end
    check("midjob_busy", 32'(busy), 32'd1);
    reset_dut("midjob_rst");

    for (int j = 5; j < 45; j++) begin
      random_job();
      run_job(j);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
